// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// counter sizing.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    SUB_IDLE  = 2'd0,
    SUB_SHIFT = 2'd1,
    SUB_DONE  = 2'd2
  } sub_state_e;

  // The bit counter only has to reach W-1.
  function automatic int sub_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Handshake/operand bus of sub_serial. The Ovf line exists only when
// SUB_SERIAL_OVF_EN is defined.
interface sub_serial_if #(
  parameter int W = 4
);
  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_bi;
  logic [W-1:0] o_d;
  logic         o_bo;
  logic         o_busy;
  logic         o_done;
`ifdef SUB_SERIAL_OVF_EN
  logic         o_ovf;

  modport master (output i_start, i_a, i_b, i_bi,
                  input  o_d, o_bo, o_busy, o_done, o_ovf);
  modport slave  (input  i_start, i_a, i_b, i_bi,
                  output o_d, o_bo, o_busy, o_done, o_ovf);
`else
  modport master (output i_start, i_a, i_b, i_bi,
                  input  o_d, o_bo, o_busy, o_done);
  modport slave  (input  i_start, i_a, i_b, i_bi,
                  output o_d, o_bo, o_busy, o_done);
`endif
endinterface

// File: rtl/sub_serial_full_sub_1b.sv
// One-bit full subtractor: d = a - b - br, with borrow-out.
module full_sub_1b (
  input  logic i_a,
  input  logic i_b,
  input  logic i_br,
  output logic o_d,
  output logic o_br
);
  assign o_d  = i_a ^ i_b ^ i_br;
  assign o_br = (~i_a & i_b) | (~(i_a ^ i_b) & i_br);
endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor D = A - B - Bi, one bit per clock, start/done handshake.
// Define SUB_SERIAL_OVF_EN to add the signed-overflow output.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int W = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  sub_serial_if.slave bus
);

  localparam int             CW   = sub_cnt_w(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  sub_state_e    r_state;
  sub_state_e    w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-2:0]  r_res;
  logic          r_br;
  logic [W-1:0]  r_d;
  logic          r_bo;
  logic          r_busy;
  logic          r_done;
  logic          w_d;
  logic          w_br;
  logic          w_accept;
  logic          w_shift;
  logic          w_last;
  logic [W-1:0]  w_res;

  full_sub_1b u_fsub (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_br (r_br),
    .o_d  (w_d),
    .o_br (w_br)
  );

  // New bit enters at the MSB; on the last shift this is the full result.
  assign w_res = {w_d, r_res};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SUB_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_shift  = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      SUB_IDLE, SUB_DONE: begin
        if (bus.i_start) begin
          w_accept = 1'b1;
          w_next   = SUB_SHIFT;
        end else begin
          w_next   = SUB_IDLE;
        end
      end
      SUB_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = SUB_DONE;
        end
      end
      default: w_next = SUB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_shift)  r_cnt <= r_cnt + 1'b1;
  end

  // Datapath shift registers carry no reset; they are reloaded on every Start.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_a  <= bus.i_a;
      r_b  <= bus.i_b;
      r_br <= bus.i_bi;
    end else if (w_shift) begin
      r_a   <= {1'b0, r_a[W-1:1]};
      r_b   <= {1'b0, r_b[W-1:1]};
      r_br  <= w_br;
      r_res <= w_res[W-1:1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_d    <= '0;
      r_bo   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == SUB_SHIFT);
      r_done <= (w_next == SUB_DONE);
      if (w_last) begin
        r_d  <= w_res;
        r_bo <= w_br;
      end
    end
  end

`ifdef SUB_SERIAL_OVF_EN
  logic r_sa;
  logic r_sb;
  logic r_ovf;

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_sa <= bus.i_a[W-1];
      r_sb <= bus.i_b[W-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_ovf <= 1'b0;
    else if (w_last) r_ovf <= (r_sa != r_sb) & (w_d != r_sa);
  end

  assign bus.o_ovf = r_ovf;
`endif

  assign bus.o_d    = r_d;
  assign bus.o_bo   = r_bo;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;

endmodule
